ddr3_ddl_cmd: RTL and testbench



---
 rtl/ddr3_ddl_cmd_pkg.sv | 47 ++++
 rtl/ddr3_refresh_timer.sv | 32 +++
 rtl/ddr3_ddl_cmd.sv | 192 +++++++++++++++++++
 tb/tb_ddr3_ddl_cmd.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_ddl_cmd_pkg.sv
// rtl/ddr3_ddl_cmd_pkg.sv - DDR3 command encodings, FSM states and default 100 MHz timing
package ddr3_ddl_cmd_pkg;

    typedef enum logic [2:0] {
        CMD_MODE = 3'b000,
        CMD_REFR = 3'b001,
        CMD_PREC = 3'b010,
        CMD_ACTV = 3'b011,
        CMD_WRIT = 3'b100,
        CMD_READ = 3'b101,
        CMD_ZQCL = 3'b110,
        CMD_NOOP = 3'b111
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REFP,
        ST_REFR
    } state_e;

    localparam int GATE_W  = 10;
    localparam int A10_BIT = 10;

    localparam int DEF_ROW_BITS = 13;
    localparam int DEF_T_RCD    = 2;
    localparam int DEF_T_RP     = 2;
    localparam int DEF_T_RAS    = 4;
    localparam int DEF_T_RFC    = 11;
    localparam int DEF_T_REFI   = 780;
    localparam int DEF_T_CCD    = 4;
    localparam int DEF_T_WTR    = 13;
    localparam int DEF_T_RTW    = 6;
    localparam int DEF_T_RDAP   = 6;
    localparam int DEF_T_WRAP   = 13;
    localparam int DEF_T_MOD    = 12;
    localparam int DEF_T_ZQ     = 512;

    // Saturating decrement, then raise to the newly requested hold-off if larger.
    function automatic logic [GATE_W-1:0] gate_next(input logic [GATE_W-1:0] cur,
                                                    input logic [GATE_W-1:0] val);
        logic [GATE_W-1:0] dec;
        dec = (cur == '0) ? '0 : cur - GATE_W'(1);
        return (val > dec) ? val : dec;
    endfunction

endpackage

// File: rtl/ddr3_refresh_timer.sv
// rtl/ddr3_refresh_timer.sv - periodic refresh interval counter with sticky pending flag
module ddr3_refresh_timer #(
    parameter int T_REFI = 780
) (
    input  logic clock,
    input  logic arst_n,
    input  logic clear,
    output logic pending
);

    localparam int CW = $clog2(T_REFI);

    logic [CW-1:0] cnt;
    logic          expire;

    assign expire = (cnt == '0);

    // A new expiry outranks a same-cycle clear so that interval is never lost.
    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            cnt     <= CW'(T_REFI - 1);
            pending <= 1'b0;
        end else begin
            cnt <= expire ? CW'(T_REFI - 1) : cnt - CW'(1);
            if (expire)
                pending <= 1'b1;
            else if (clear)
                pending <= 1'b0;
        end
    end

endmodule

// File: rtl/ddr3_ddl_cmd.sv
// rtl/ddr3_ddl_cmd.sv - stages one DDL command and issues it on DFI once JEDEC gates allow
module ddr3_ddl_cmd
    import ddr3_ddl_cmd_pkg::*;
#(
    parameter int DDR_ROW_BITS = DEF_ROW_BITS,
    parameter int T_RCD        = DEF_T_RCD,
    parameter int T_RP         = DEF_T_RP,
    parameter int T_RAS        = DEF_T_RAS,
    parameter int T_RFC        = DEF_T_RFC,
    parameter int T_REFI       = DEF_T_REFI,
    parameter int T_CCD        = DEF_T_CCD,
    parameter int T_WTR        = DEF_T_WTR,
    parameter int T_RTW        = DEF_T_RTW,
    parameter int T_RDAP       = DEF_T_RDAP,
    parameter int T_WRAP       = DEF_T_WRAP,
    parameter int T_MOD        = DEF_T_MOD,
    parameter int T_ZQ         = DEF_T_ZQ
) (
    input  logic                    clock,
    input  logic                    arst_n,
    input  logic                    ddl_req_i,
    input  logic                    ddl_seq_i,
    output logic                    ddl_rdy_o,
    output logic                    ddl_ref_o,
    input  logic [2:0]              ddl_cmd_i,
    input  logic [2:0]              ddl_ba_i,
    input  logic [DDR_ROW_BITS-1:0] ddl_adr_i,
    output logic                    dfi_cs_n_o,
    output logic                    dfi_ras_n_o,
    output logic                    dfi_cas_n_o,
    output logic                    dfi_we_n_o,
    output logic [2:0]              dfi_ba_o,
    output logic [DDR_ROW_BITS-1:0] dfi_adr_o
);

    // A gate loaded with G-1 reaches zero in time for issue exactly G cycles later.
    localparam logic [GATE_W-1:0] L_RCD   = GATE_W'(T_RCD - 1);
    localparam logic [GATE_W-1:0] L_RP    = GATE_W'(T_RP - 1);
    localparam logic [GATE_W-1:0] L_RAS   = GATE_W'(T_RAS - 1);
    localparam logic [GATE_W-1:0] L_RFC   = GATE_W'(T_RFC - 1);
    localparam logic [GATE_W-1:0] L_CCD   = GATE_W'(T_CCD - 1);
    localparam logic [GATE_W-1:0] L_WTR   = GATE_W'(T_WTR - 1);
    localparam logic [GATE_W-1:0] L_RTW   = GATE_W'(T_RTW - 1);
    localparam logic [GATE_W-1:0] L_RDAP  = GATE_W'(T_RDAP - 1);
    localparam logic [GATE_W-1:0] L_WRAP  = GATE_W'(T_WRAP - 1);
    localparam logic [GATE_W-1:0] L_RDPRE = GATE_W'(T_RDAP - T_RP - 1);
    localparam logic [GATE_W-1:0] L_WRPRE = GATE_W'(T_WRAP - T_RP - 1);
    localparam logic [GATE_W-1:0] L_MOD   = GATE_W'(T_MOD - 1);
    localparam logic [GATE_W-1:0] L_ZQ    = GATE_W'(T_ZQ - 1);
    localparam logic [DDR_ROW_BITS-1:0] PREA_ADR =
        {{(DDR_ROW_BITS-1-A10_BIT){1'b0}}, 1'b1, {A10_BIT{1'b0}}};

    state_e                  state;
    cmd_e                    stg_cmd;
    logic [2:0]              stg_ba;
    logic [DDR_ROW_BITS-1:0] stg_adr;
    logic [GATE_W-1:0]       g_act, g_rd, g_wr, g_pre;
    logic [GATE_W-1:0]       v_act, v_rd, v_wr, v_pre;
    logic                    issue;
    cmd_e                    iss_cmd;
    logic [DDR_ROW_BITS-1:0] iss_adr;
    logic                    unused_seq;

    assign unused_seq = ddl_seq_i;

    ddr3_refresh_timer #(.T_REFI(T_REFI)) u_refresh_timer (
        .clock   (clock),
        .arst_n  (arst_n),
        .clear   (issue && (state == ST_REFP)),
        .pending (ddl_ref_o)
    );

    always_comb begin
        issue   = 1'b0;
        iss_cmd = stg_cmd;
        iss_adr = stg_adr;
        case (state)
            ST_HOLD: begin
                case (stg_cmd)
                    CMD_READ: issue = (g_rd == '0);
                    CMD_WRIT: issue = (g_wr == '0);
                    CMD_PREC: issue = (g_pre == '0);
                    CMD_REFR: begin
                        issue   = (g_pre == '0) && (g_act == '0);
                        iss_cmd = CMD_PREC;
                        iss_adr = PREA_ADR;
                    end
                    default:  issue = (g_act == '0);
                endcase
            end
            ST_REFP: begin
                issue   = (g_act == '0);
                iss_cmd = CMD_REFR;
            end
            default: ;
        endcase
    end

    always_comb begin
        v_act = '0;
        v_rd  = '0;
        v_wr  = '0;
        v_pre = '0;
        if (issue) begin
            case (iss_cmd)
                CMD_ACTV: begin
                    v_rd  = L_RCD;
                    v_wr  = L_RCD;
                    v_pre = L_RAS;
                end
                CMD_READ: begin
                    v_rd  = L_CCD;
                    v_wr  = L_RTW;
                    v_pre = L_RDPRE;
                    if (iss_adr[A10_BIT]) v_act = L_RDAP;
                end
                CMD_WRIT: begin
                    v_wr  = L_CCD;
                    v_rd  = L_WTR;
                    v_pre = L_WRPRE;
                    if (iss_adr[A10_BIT]) v_act = L_WRAP;
                end
                CMD_PREC: v_act = L_RP;
                CMD_MODE: {v_act, v_rd, v_wr, v_pre} = {4{L_MOD}};
                CMD_ZQCL: {v_act, v_rd, v_wr, v_pre} = {4{L_ZQ}};
                CMD_REFR: {v_act, v_rd, v_wr, v_pre} = {4{L_RFC}};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            state       <= ST_IDLE;
            ddl_rdy_o   <= 1'b0;
            stg_cmd     <= CMD_NOOP;
            stg_ba      <= '0;
            stg_adr     <= '0;
            g_act       <= '0;
            g_rd        <= '0;
            g_wr        <= '0;
            g_pre       <= '0;
            dfi_cs_n_o  <= 1'b1;
            dfi_ras_n_o <= 1'b1;
            dfi_cas_n_o <= 1'b1;
            dfi_we_n_o  <= 1'b1;
            dfi_ba_o    <= '0;
            dfi_adr_o   <= '0;
        end else begin
            g_act <= gate_next(g_act, v_act);
            g_rd  <= gate_next(g_rd,  v_rd);
            g_wr  <= gate_next(g_wr,  v_wr);
            g_pre <= gate_next(g_pre, v_pre);

            dfi_cs_n_o <= !issue;
            {dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} <= issue ? iss_cmd : 3'b111;
            if (issue) begin
                dfi_ba_o  <= stg_ba;
                dfi_adr_o <= iss_adr;
            end

            case (state)
                ST_IDLE: begin
                    ddl_rdy_o <= 1'b1;
                    if (ddl_req_i && ddl_rdy_o) begin
                        stg_cmd <= cmd_e'(ddl_cmd_i);
                        stg_ba  <= ddl_ba_i;
                        stg_adr <= ddl_adr_i;
                        if (cmd_e'(ddl_cmd_i) != CMD_NOOP) begin
                            state     <= ST_HOLD;
                            ddl_rdy_o <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (issue) begin
                        state     <= (stg_cmd == CMD_REFR) ? ST_REFP : ST_IDLE;
                        ddl_rdy_o <= (stg_cmd != CMD_REFR);
                    end
                end
                ST_REFP: begin
                    if (issue) state <= ST_REFR;
                end
                default: begin
                    state     <= ST_IDLE;
                    ddl_rdy_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_ddl_cmd.sv
// tb/tb_ddr3_ddl_cmd.sv - directed table-driven bench for ddr3_ddl_cmd
module tb_ddr3_ddl_cmd;
    import ddr3_ddl_cmd_pkg::*;

    logic        clock = 1'b0;
    logic        arst_n = 1'b0;
    logic        req = 1'b0;
    logic        seq = 1'b0;
    logic [2:0]  cmd = 3'b111;
    logic [2:0]  ba = 3'd0;
    logic [12:0] adr = 13'd0;
    logic        rdy, refd, cs_n, ras_n, cas_n, we_n;
    logic [2:0]  dfi_ba;
    logic [12:0] dfi_adr;

    ddr3_ddl_cmd dut (
        .clock       (clock),
        .arst_n      (arst_n),
        .ddl_req_i   (req),
        .ddl_seq_i   (seq),
        .ddl_rdy_o   (rdy),
        .ddl_ref_o   (refd),
        .ddl_cmd_i   (cmd),
        .ddl_ba_i    (ba),
        .ddl_adr_i   (adr),
        .dfi_cs_n_o  (cs_n),
        .dfi_ras_n_o (ras_n),
        .dfi_cas_n_o (cas_n),
        .dfi_we_n_o  (we_n),
        .dfi_ba_o    (dfi_ba),
        .dfi_adr_o   (dfi_adr)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0] c1;
        logic       a1;
        logic [2:0] c2;
        logic       a2;
        int         dly;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [2:0] c, input logic [2:0] b, input logic [12:0] a);
        int n;
        n = 0;
        cmd = c;
        ba  = b;
        adr = a;
        req = 1'b1;
        while (!rdy && n < 700) begin
            tick();
            n++;
        end
        check("rdy_wait", (n < 700), 1);
        tick();
        req = 1'b0;
        cmd = 3'b111;
    endtask

    task automatic wait_issue(output int t);
        int n;
        n = 0;
        t = -1;
        tick();
        while (cs_n && n < 700) begin
            tick();
            n++;
        end
        if (!cs_n) t = cyc;
        else check("issue_timeout", 0, 1);
    endtask

    initial begin
        int c0, n, busy, t1, t2, tref, tacc;
        logic [12:0] a1, a2;

        tbl[0]  = '{CMD_ACTV, 1'b0, CMD_READ, 1'b0, 2};
        tbl[1]  = '{CMD_ACTV, 1'b0, CMD_WRIT, 1'b0, 2};
        tbl[2]  = '{CMD_ACTV, 1'b0, CMD_PREC, 1'b0, 4};
        tbl[3]  = '{CMD_ACTV, 1'b0, CMD_ACTV, 1'b0, 2};
        tbl[4]  = '{CMD_WRIT, 1'b0, CMD_READ, 1'b0, 13};
        tbl[5]  = '{CMD_READ, 1'b0, CMD_WRIT, 1'b0, 6};
        tbl[6]  = '{CMD_READ, 1'b0, CMD_READ, 1'b0, 4};
        tbl[7]  = '{CMD_WRIT, 1'b0, CMD_WRIT, 1'b0, 4};
        tbl[8]  = '{CMD_WRIT, 1'b1, CMD_ACTV, 1'b0, 13};
        tbl[9]  = '{CMD_READ, 1'b1, CMD_ACTV, 1'b0, 6};
        tbl[10] = '{CMD_WRIT, 1'b0, CMD_ACTV, 1'b0, 2};
        tbl[11] = '{CMD_READ, 1'b0, CMD_PREC, 1'b0, 4};
        tbl[12] = '{CMD_WRIT, 1'b0, CMD_PREC, 1'b0, 11};
        tbl[13] = '{CMD_PREC, 1'b0, CMD_ACTV, 1'b0, 2};
        tbl[14] = '{CMD_MODE, 1'b0, CMD_READ, 1'b0, 12};
        tbl[15] = '{CMD_ZQCL, 1'b0, CMD_ACTV, 1'b0, 512};

        repeat (3) @(posedge clock);
        #1;
        check("reset_rdy", rdy, 0);
        check("reset_ref", refd, 0);
        check("reset_pins", {cs_n, ras_n, cas_n, we_n}, 4'b1111);
        check("reset_ba_adr", {dfi_ba, dfi_adr}, 0);

        @(negedge clock);
        arst_n = 1'b1;
        c0 = cyc;
        tick();
        check("rdy_first_edge", rdy, 1);
        n = 0;
        busy = 0;
        while (!refd && n < 900) begin
            tick();
            n++;
            if (!cs_n) busy = 1;
        end
        check("ref_interval", cyc - c0, 780);
        check("idle_pins_nop", busy, 0);

        send(CMD_REFR, 3'd0, 13'd0);
        tick();
        check("refp_pins", {cs_n, ras_n, cas_n, we_n, dfi_adr[10]}, {1'b0, CMD_PREC, 1'b1});
        tick();
        check("ref_gap", {cs_n, refd}, 2'b11);
        tick();
        check("ref_pins", {cs_n, ras_n, cas_n, we_n}, {1'b0, CMD_REFR});
        check("ref_clear", refd, 0);
        check("ref_rdy_low", rdy, 0);
        tref = cyc;
        tick();
        check("ref_rdy_back", rdy, 1);
        send(CMD_ACTV, 3'd3, 13'h0055);
        wait_issue(t2);
        check("ref_to_act", t2 - tref, 11);
        repeat (20) tick();

        send(CMD_NOOP, 3'd1, 13'h0001);
        check("noop_rdy", rdy, 1);
        busy = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (!cs_n) busy = 1;
        end
        check("noop_no_pins", busy, 0);

        for (int i = 0; i < 16; i++) begin
            a1 = {2'b00, tbl[i].a1, 10'h012};
            a2 = {2'b00, tbl[i].a2, 10'h034};
            send(tbl[i].c1, 3'd1, a1);
            wait_issue(t1);
            check($sformatf("v%0d_c1_pins", i), {ras_n, cas_n, we_n}, tbl[i].c1);
            send(tbl[i].c2, 3'd6, a2);
            wait_issue(t2);
            check($sformatf("v%0d_delay", i), t2 - t1, tbl[i].dly);
            check($sformatf("v%0d_c2_pins", i), {ras_n, cas_n, we_n, dfi_ba, dfi_adr},
                  {tbl[i].c2, 3'd6, a2});
            tick();
            check($sformatf("v%0d_one_cycle", i), cs_n, 1);
            repeat (40) tick();
        end

        send(CMD_WRIT, 3'd5, 13'h0abc);
        wait_issue(t1);
        send(CMD_READ, 3'd5, 13'h0010);
        tick();
        #3;
        arst_n = 1'b0;
        #1;
        check("arst_async", {rdy, refd, cs_n, ras_n, cas_n, we_n, dfi_ba, dfi_adr},
              {1'b0, 1'b0, 4'b1111, 3'd0, 13'd0});
        @(negedge clock);
        arst_n = 1'b1;
        tick();
        check("arst_rdy_back", rdy, 1);
        busy = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (!cs_n) busy = 1;
        end
        check("arst_read_dropped", busy, 0);
        send(CMD_READ, 3'd2, 13'h0020);
        tacc = cyc;
        wait_issue(t2);
        check("arst_gates_clear", t2 - tacc, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
